// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared types and byte constants for the PS/2 host command sequencer.
package ps2_cmd_sequencer_pkg;

  localparam logic [7:0] BYTE_ACK       = 8'hFA;
  localparam logic [7:0] BYTE_RESEND    = 8'hFE;
  localparam logic [7:0] BYTE_BAT_OK    = 8'hAA;
  localparam logic [7:0] BYTE_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] BYTE_CMD_RESET = 8'hFF;

  // Receive error flags reported by ps2_controller alongside each byte.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic rx_timeout;
  } flags_t;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_NACK     = 2'd1,
    STATUS_TIMEOUT  = 2'd2,
    STATUS_BAT_FAIL = 2'd3
  } cmd_status_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_WAIT_BAT = 3'd4,
    S_FINISH   = 3'd5
  } seq_state_t;

  function automatic logic flags_bad(input flags_t f);
    return |f;
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Command request/completion handshake and scancode stream between system logic and the sequencer.
interface ps2_cmd_sequencer_if;
  import ps2_cmd_sequencer_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_byte;
  logic        cmd_has_arg;
  logic [7:0]  cmd_arg;
  logic        cmd_done;
  cmd_status_t cmd_status;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  code_data;
  logic        rx_err;
  logic        overflow;

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, code_ready,
    input  cmd_ready, cmd_done, cmd_status, code_valid, code_data, rx_err, overflow
  );

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg, code_ready,
    output cmd_ready, cmd_done, cmd_status, code_valid, code_data, rx_err, overflow
  );

endinterface

// File: rtl/ps2_cmd_sequencer_rx_fifo.sv
// ps2_rx_fifo: byte-wide synchronous FIFO holding forwarded scancodes.
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        wr_en;
  logic        rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: sends commands, handles ACK/resend/BAT, and
// forwards unsolicited bytes to a scancode FIFO.
module ps2_cmd_sequencer
  import ps2_cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int RX_DEPTH       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ps2_cmd_sequencer_if.slave    bus,
  output logic                  ps2_en_o,
  output logic                  ps2_tx_rqst_o,
  output logic [7:0]            ps2_tx_data_o,
  input  logic                  ps2_valid_i,
  input  logic [7:0]            ps2_rx_data_i,
  input  flags_t                ps2_flags_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  seq_state_t  state_q;
  logic [7:0]  op_q;
  logic [7:0]  arg_q;
  logic        has_arg_q;
  logic        arg_phase_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] tmo_q;
  logic        tx_rqst_q;
  logic [7:0]  tx_data_q;
  logic        ready_q;
  logic        done_q;
  cmd_status_t status_q;
  cmd_status_t fin_status_q;
  logic        rx_err_q;
  logic        overflow_q;

  logic        rx_clean;
  logic        rx_bad;
  logic        is_ack;
  logic        is_resend;
  logic        is_bat_ok;
  logic        is_bat_fail;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tmo_hit;
  logic        retry_ok;

  always_comb begin
    rx_clean    = ps2_valid_i && !flags_bad(ps2_flags_i);
    rx_bad      = ps2_valid_i && flags_bad(ps2_flags_i);
    is_ack      = (ps2_rx_data_i == BYTE_ACK);
    is_resend   = (ps2_rx_data_i == BYTE_RESEND);
    is_bat_ok   = (ps2_rx_data_i == BYTE_BAT_OK);
    is_bat_fail = (ps2_rx_data_i == BYTE_BAT_FAIL);
    tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    retry_ok    = (retry_q < RW'(MAX_RETRIES));
    push        = 1'b0;
    // Bytes arriving while a tx is in flight belong to an aborted frame and are dropped.
    case (state_q)
      S_IDLE, S_FINISH: push = rx_clean;
      S_WAIT_ACK:       push = rx_clean && !is_ack && !is_resend;
      S_WAIT_BAT:       push = rx_clean && !is_bat_ok && !is_bat_fail;
      default:          push = 1'b0;
    endcase
  end

  assign pop = bus.code_ready && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      arg_phase_q  <= 1'b0;
      retry_q      <= '0;
      tmo_q        <= '0;
      tx_rqst_q    <= 1'b0;
      tx_data_q    <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= STATUS_OK;
      fin_status_q <= STATUS_OK;
      rx_err_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      tx_rqst_q <= 1'b0;
      done_q    <= 1'b0;
      rx_err_q  <= rx_bad && (state_q != S_WAIT_TX);
      if (push && fifo_full) overflow_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ready_q && bus.cmd_valid) begin
            op_q        <= bus.cmd_byte;
            arg_q       <= bus.cmd_arg;
            has_arg_q   <= bus.cmd_has_arg;
            arg_phase_q <= 1'b0;
            retry_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= S_SEND;
          end else begin
            ready_q <= 1'b1;
          end
        end

        S_SEND: begin
          tx_rqst_q <= 1'b1;
          tx_data_q <= arg_phase_q ? arg_q : op_q;
          tmo_q     <= '0;
          state_q   <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (rx_clean) begin
            tmo_q   <= '0;
            state_q <= S_WAIT_ACK;
          end else if (rx_bad) begin
            if (retry_ok) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_SEND;
            end else begin
              fin_status_q <= STATUS_NACK;
              state_q      <= S_FINISH;
            end
          end else if (tmo_hit) begin
            fin_status_q <= STATUS_TIMEOUT;
            state_q      <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_WAIT_ACK: begin
          if (rx_clean && is_ack) begin
            if (!arg_phase_q && has_arg_q) begin
              arg_phase_q <= 1'b1;
              retry_q     <= '0;
              state_q     <= S_SEND;
            end else if (op_q == BYTE_CMD_RESET) begin
              tmo_q   <= '0;
              state_q <= S_WAIT_BAT;
            end else begin
              fin_status_q <= STATUS_OK;
              state_q      <= S_FINISH;
            end
          end else if (rx_clean && is_resend) begin
            if (retry_ok) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_SEND;
            end else begin
              fin_status_q <= STATUS_NACK;
              state_q      <= S_FINISH;
            end
          end else if (tmo_hit) begin
            fin_status_q <= STATUS_TIMEOUT;
            state_q      <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_WAIT_BAT: begin
          if (rx_clean && is_bat_ok) begin
            fin_status_q <= STATUS_OK;
            state_q      <= S_FINISH;
          end else if (rx_clean && is_bat_fail) begin
            fin_status_q <= STATUS_BAT_FAIL;
            state_q      <= S_FINISH;
          end else if (tmo_hit) begin
            fin_status_q <= STATUS_TIMEOUT;
            state_q      <= S_FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_FINISH: begin
          done_q   <= 1'b1;
          status_q <= fin_status_q;
          ready_q  <= 1'b1;
          state_q  <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  ps2_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (ps2_rx_data_i),
    .pop_i   (pop),
    .data_o  (bus.code_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reset gates the request and ready combinationally so an abort takes effect without waiting an edge.
  assign ps2_en_o       = !rst_i;
  assign ps2_tx_rqst_o  = tx_rqst_q && !rst_i;
  assign ps2_tx_data_o  = tx_data_q;
  assign bus.cmd_ready  = ready_q && !rst_i;
  assign bus.cmd_done   = done_q;
  assign bus.cmd_status = status_q;
  assign bus.code_valid = !fifo_empty;
  assign bus.rx_err     = rx_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer; the bench plays the ps2_controller and the device.
module tb_ps2_cmd_sequencer;
  import ps2_cmd_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_en;
  logic        ps2_tx_rqst;
  logic [7:0]  ps2_tx_data;
  logic        ps2_valid;
  logic [7:0]  ps2_rx_data;
  flags_t      ps2_flags;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int tx_cnt   = 0;
  cmd_status_t last_status = STATUS_OK;

  ps2_cmd_sequencer_if bus ();

  ps2_cmd_sequencer #(
    .TIMEOUT_CYCLES(1000),
    .MAX_RETRIES   (3),
    .RX_DEPTH      (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .ps2_en_o      (ps2_en),
    .ps2_tx_rqst_o (ps2_tx_rqst),
    .ps2_tx_data_o (ps2_tx_data),
    .ps2_valid_i   (ps2_valid),
    .ps2_rx_data_i (ps2_rx_data),
    .ps2_flags_i   (ps2_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cmd_done === 1'b1) begin
      done_cnt    <= done_cnt + 1;
      last_status <= bus.cmd_status;
      done_cyc    <= cyc;
    end
    if (ps2_tx_rqst === 1'b1) tx_cnt <= tx_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input flags_t f);
    ps2_valid   = 1'b1;
    ps2_rx_data = b;
    ps2_flags   = f;
    tick();
    ps2_valid   = 1'b0;
    ps2_rx_data = 8'h00;
    ps2_flags   = '0;
  endtask

  task automatic issue(input logic [7:0] op, input logic has, input logic [7:0] arg);
    check("cmd_ready before issue", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_byte    = op;
    bus.cmd_has_arg = has;
    bus.cmd_arg     = arg;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_rqst();
    int n = 0;
    while (ps2_tx_rqst !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tx_rqst seen", ps2_tx_rqst, 1);
  endtask

  // Wait for the request, report tx completion, then answer with resp.
  task automatic serve(input logic [7:0] resp, output logic [7:0] txb);
    wait_rqst();
    txb = ps2_tx_data;
    tick();
    rx_byte(8'h00, '0);
    tick();
    rx_byte(resp, '0);
  endtask

  task automatic wait_done(input int prev, input cmd_status_t st, input string tag);
    int n = 0;
    while (done_cnt == prev && n < 1500) begin
      tick();
      n++;
    end
    check({tag, " done count"}, done_cnt, prev + 1);
    check({tag, " status"}, last_status, st);
  endtask

  task automatic pop();
    bus.code_ready = 1'b1;
    tick();
    bus.code_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] txb;
    int p;
    int t0;
    int e;

    rst             = 1'b1;
    ps2_valid       = 1'b0;
    ps2_rx_data     = 8'h00;
    ps2_flags       = '0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_byte    = 8'h00;
    bus.cmd_has_arg = 1'b0;
    bus.cmd_arg     = 8'h00;
    bus.code_ready  = 1'b0;
    tick(); tick(); tick();

    check("rst ps2_en", ps2_en, 0);
    check("rst cmd_ready", bus.cmd_ready, 0);
    check("rst tx_rqst", ps2_tx_rqst, 0);
    check("rst tx_data", ps2_tx_data, 0);
    check("rst cmd_done", bus.cmd_done, 0);
    check("rst cmd_status", bus.cmd_status, STATUS_OK);
    check("rst code_valid", bus.code_valid, 0);
    check("rst rx_err", bus.rx_err, 0);
    check("rst overflow", bus.overflow, 0);

    rst = 1'b0;
    #1;
    check("ps2_en out of reset", ps2_en, 1);
    tick();
    check("cmd_ready after reset", bus.cmd_ready, 1);

    // Two-byte command 0xED 0x02, both ACKed.
    p = done_cnt;
    issue(8'hED, 1'b1, 8'h02);
    check("rqst one cycle after accept", ps2_tx_rqst, 0);
    tick();
    check("rqst two cycles after accept", ps2_tx_rqst, 1);
    serve(8'hFA, txb);
    check("ED opcode byte", txb, 8'hED);
    serve(8'hFA, txb);
    check("ED arg byte", txb, 8'h02);
    wait_done(p, STATUS_OK, "ED");
    tick(); tick(); tick();
    check("ED single done", done_cnt, p + 1);

    // 0xF4 resent twice then ACKed; done follows the ACK by two cycles.
    p  = done_cnt;
    t0 = tx_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    serve(8'hFE, txb);
    check("F4 tx 1", txb, 8'hF4);
    serve(8'hFE, txb);
    check("F4 tx 2", txb, 8'hF4);
    serve(8'hFA, txb);
    check("F4 tx 3", txb, 8'hF4);
    check("F4 done not yet", bus.cmd_done, 0);
    tick();
    check("F4 done pulse", bus.cmd_done, 1);
    check("F4 status", bus.cmd_status, STATUS_OK);
    tick();
    check("F4 done cleared", bus.cmd_done, 0);
    check("F4 transmissions", tx_cnt - t0, 3);
    check("F4 done count", done_cnt, p + 1);

    // Resend four times: initial try plus three retries, then NACK.
    p  = done_cnt;
    t0 = tx_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) serve(8'hFE, txb);
    wait_done(p, STATUS_NACK, "NACK");
    for (int i = 0; i < 10; i++) tick();
    check("NACK transmissions", tx_cnt - t0, 4);

    // Reset command with a scancode interleaved before BAT OK.
    p = done_cnt;
    issue(8'hFF, 1'b0, 8'h00);
    serve(8'hFA, txb);
    tick();
    rx_byte(8'h1C, '0);
    tick();
    rx_byte(8'hAA, '0);
    wait_done(p, STATUS_OK, "BAT ok");
    check("BAT fifo valid", bus.code_valid, 1);
    check("BAT fifo data", bus.code_data, 8'h1C);
    pop();
    check("BAT fifo drained", bus.code_valid, 0);

    p = done_cnt;
    issue(8'hFF, 1'b0, 8'h00);
    serve(8'hFA, txb);
    tick();
    rx_byte(8'hFC, '0);
    wait_done(p, STATUS_BAT_FAIL, "BAT fail");
    check("BAT fail fifo empty", bus.code_valid, 0);

    // Errored byte in IDLE pulses rx_err and is dropped; stray ACK in IDLE is forwarded.
    rx_byte(8'h55, 3'b100);
    check("rx_err pulse", bus.rx_err, 1);
    tick();
    check("rx_err cleared", bus.rx_err, 0);
    check("errored byte dropped", bus.code_valid, 0);
    rx_byte(8'hFA, '0);
    check("stray ack pushed", bus.code_valid, 1);
    check("stray ack data", bus.code_data, 8'hFA);
    pop();
    check("stray ack popped", bus.code_valid, 0);

    // Silent device: FSM leaves WAIT_ACK 1000 cycles after entry, done registered one later.
    p = done_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    wait_rqst();
    tick();
    rx_byte(8'h00, '0);
    e = cyc;
    wait_done(p, STATUS_TIMEOUT, "timeout");
    check("timeout latency", done_cyc - e, 1001);

    // Nine scancodes into an eight-deep FIFO with no consumer.
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i), '0);
    check("no overflow at full", bus.overflow, 0);
    rx_byte(8'h18, '0);
    check("overflow set", bus.overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check("fifo order", bus.code_data, 8'h10 + 8'(i));
      pop();
    end
    check("fifo empty after pops", bus.code_valid, 0);
    check("overflow sticky", bus.overflow, 1);

    // Reset while the request is on the wire.
    p = done_cnt;
    issue(8'hF4, 1'b0, 8'h00);
    tick();
    check("rqst before abort", ps2_tx_rqst, 1);
    rst = 1'b1;
    #1;
    check("rqst dropped by rst", ps2_tx_rqst, 0);
    tick();
    rst = 1'b0;
    tick();
    check("ready after abort", bus.cmd_ready, 1);
    check("overflow cleared by rst", bus.overflow, 0);
    for (int i = 0; i < 5; i++) tick();
    check("no done after abort", done_cnt, p);
    check("no rqst after abort", ps2_tx_rqst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
